instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, PC value after reset.
REQ-002 SHALL have parameter INSTR_BYTES, default 3, bytes per instruction (fixed at 3 in this revision).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port IR_load  input  1  fetch-next-instruction request from ControlUnit.
REQ-006 SHALL have port PC_en  input  1  PC redirect strobe (jump/call/ret).
REQ-007 SHALL have port PC_load  input  8  redirect target address.
REQ-008 SHALL have port mem_addr  output  8  byte address to instruction memory.
REQ-009 SHALL have port mem_req  output  1  read request, held until acknowledged.
REQ-010 SHALL have port mem_data  input  8  read byte, valid when mem_ack=1.
REQ-011 SHALL have port mem_ack  input  1  read completion, may assert in the same cycle as mem_req.
REQ-012 SHALL have port command_word  output  24  assembled instruction {opcode, field1, field2} for ControlUnit.
REQ-013 SHALL have port cw_valid  output  1  one-cycle pulse, new command_word available.
REQ-014 SHALL have port busy  output  1  high while a fetch is in progress.
REQ-015 SHALL have port pc  output  8  current program counter.

Function
REQ-016 SHALL implement FSM states IDLE, B0, B1, B2; busy=1 exactly in B0/B1/B2.
REQ-017 In IDLE with IR_load=1, SHALL go to B0 on the next edge; IR_load outside IDLE SHALL be ignored.
REQ-018 In Bn, SHALL drive mem_req=1 and mem_addr=pc combinationally from registered pc.
REQ-019 On Bn with mem_ack=1, SHALL capture mem_data into byte n (B0->[23:16], B1->[15:8], B2->[7:0]), increment pc by 1 mod 256, and advance B0->B1->B2->IDLE; without mem_ack, SHALL stay in Bn.
REQ-020 command_word SHALL update atomically only on B2 completion; partially fetched bytes SHALL be held in a separate shadow register.
REQ-021 cw_valid SHALL be 1 for exactly the one cycle following B2 completion (registered), 0 otherwise.
REQ-022 Minimum latency: IR_load at cycle t with mem_ack always 1 -> cw_valid=1 at cycle t+4.
REQ-023 pc SHALL wrap 8'hFF -> 8'h00 without error indication; a fetch starting at 8'hFE SHALL read FE, FF, 00.
REQ-024 PC_en=1 in IDLE SHALL load pc<=PC_load on the next edge.
REQ-025 PC_en=1 in Bn SHALL abort: pc<=PC_load, shadow discarded, state->IDLE, no cw_valid, command_word unchanged; mem_data/mem_ack that cycle ignored.
REQ-026 PC_en and IR_load together in IDLE: pc<=PC_load and state->B0; the fetch SHALL use the new pc.
REQ-027 mem_ack while mem_req=0 SHALL be ignored.

Reset
REQ-028 rst=1 SHALL set state=IDLE, pc=RESET_PC, command_word=0, shadow=0, cw_valid=0, and SHALL take priority over all other inputs.
REQ-029 rst asserted mid-fetch SHALL abandon the fetch; mem_req SHALL be 0 in the cycle after the reset edge.

Structure
REQ-030 A shared package SHALL hold the fetch-state encoding, CW_W=24, BYTE_W=8, and INSTR_BYTES.
REQ-031 pc register, increment and wrap SHALL be a sub-module program_counter (inputs inc, load, load_val; output pc).
REQ-032 The FSM, shadow and command_word registers SHALL reside in instr_fetch_unit.

Verification
REQ-033 Reset then IR_load, memory[0..2]=01,02,03 with ack every cycle -> command_word=24'h010203, cw_valid at t+4, pc=3.
REQ-034 ack delayed 2 cycles per byte -> cw_valid at t+10, busy high t+1..t+9, mem_addr held stable while waiting.
REQ-035 PC_en=1, PC_load=8'h40 while in B1 -> no cw_valid, command_word unchanged, pc=8'h40; next IR_load fetches 40,41,42.
REQ-036 pc=8'hFE, memory FE,FF,00 = 19,00,0A -> command_word=24'h19000A, pc=8'h01.
REQ-037 IR_load+PC_en, PC_load=8'h10 in IDLE -> first mem_addr=8'h10; IR_load re-pulsed during B1 -> exactly one cw_valid.
REQ-038 rst asserted in B2 -> mem_req=0 next cycle, pc=RESET_PC, cw_valid never pulses.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, instruction
// length and the fetch-state encoding.
package instr_fetch_unit_pkg;

    localparam int CW_W        = 24;
    localparam int BYTE_W      = 8;
    localparam int INSTR_BYTES = 3;

    // IDLE waits for a fetch request; B0..B2 each fetch one instruction byte.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_B0   = 2'd1,
        ST_B1   = 2'd2,
        ST_B2   = 2'd3
    } fetch_state_t;

endpackage : instr_fetch_unit_pkg

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port between the fetch unit and instruction memory.
//
// Handshake: mem_req acts as valid and mem_ack as ready. The master holds
// mem_req and a stable mem_addr until a cycle in which mem_ack=1; that cycle
// completes the transfer and mem_data is consumed in it. mem_ack may be high
// in the very first cycle of mem_req. mem_ack while mem_req=0 carries no
// meaning and is ignored.
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic [BYTE_W-1:0] mem_addr;
    logic              mem_req;
    logic [BYTE_W-1:0] mem_data;
    logic              mem_ack;

    modport master (
        output mem_addr,
        output mem_req,
        input  mem_data,
        input  mem_ack
    );

    modport slave (
        input  mem_addr,
        input  mem_req,
        output mem_data,
        output mem_ack
    );

endinterface : instr_fetch_unit_if

// File: rtl/program_counter.sv
// Program counter: reset value, redirect load and +1 increment that wraps
// naturally at the byte boundary.
module program_counter
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [BYTE_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              load,
    input  logic [BYTE_W-1:0] load_val,
    output logic [BYTE_W-1:0] pc
);

    logic [BYTE_W-1:0] r_pc;

    // Redirect wins over increment; 8'hFF + 1 rolls over to 8'h00.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (load) begin
            r_pc <= load_val;
        end else if (inc) begin
            r_pc <= r_pc + 8'd1;
        end
    end

    assign pc = r_pc;

endmodule : program_counter

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: on request, reads three consecutive bytes starting
// at pc and presents them as one command word. A redirect during a fetch
// aborts it and leaves the previous command word in place.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [BYTE_W-1:0] RESET_PC    = 8'h00,
    parameter int                INSTR_BYTES = instr_fetch_unit_pkg::INSTR_BYTES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      IR_load,
    input  logic                      PC_en,
    input  logic [BYTE_W-1:0]         PC_load,
    instr_fetch_unit_if.master        mem,
    output logic [CW_W-1:0]           command_word,
    output logic                      cw_valid,
    output logic                      busy,
    output logic [BYTE_W-1:0]         pc,
    output fetch_state_t              dbg_state
);

    // Bytes gathered before the last one are parked here so the visible
    // command word only ever changes as a whole.
    localparam int SHADOW_W = (INSTR_BYTES - 1) * BYTE_W;

    fetch_state_t        r_state;
    logic [SHADOW_W-1:0] r_shadow;
    logic [CW_W-1:0]     r_command_word;
    logic                r_cw_valid;

    logic                w_fetching;
    logic                w_pc_inc;
    logic [BYTE_W-1:0]   w_pc;

    assign w_fetching = (r_state != ST_IDLE);
    // Advance only on an accepted byte that is not being overridden by a redirect.
    assign w_pc_inc   = w_fetching && mem.mem_ack && !PC_en;

    program_counter #(
        .RESET_PC (RESET_PC)
    ) u_program_counter (
        .clk      (clk),
        .rst      (rst),
        .inc      (w_pc_inc),
        .load     (PC_en),
        .load_val (PC_load),
        .pc       (w_pc)
    );

    // Fetch sequencing, byte capture and command word publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_shadow       <= '0;
            r_command_word <= '0;
            r_cw_valid     <= 1'b0;
        end else begin
            r_cw_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (IR_load) begin
                        r_state <= ST_B0;
                    end
                end
                ST_B0: begin
                    if (PC_en) begin
                        r_state  <= ST_IDLE;
                        r_shadow <= '0;
                    end else if (mem.mem_ack) begin
                        r_shadow[SHADOW_W-1 -: BYTE_W] <= mem.mem_data;
                        r_state                        <= ST_B1;
                    end
                end
                ST_B1: begin
                    if (PC_en) begin
                        r_state  <= ST_IDLE;
                        r_shadow <= '0;
                    end else if (mem.mem_ack) begin
                        r_shadow[SHADOW_W-BYTE_W-1 -: BYTE_W] <= mem.mem_data;
                        r_state                               <= ST_B2;
                    end
                end
                ST_B2: begin
                    if (PC_en) begin
                        r_state  <= ST_IDLE;
                        r_shadow <= '0;
                    end else if (mem.mem_ack) begin
                        r_command_word <= {r_shadow, mem.mem_data};
                        r_shadow       <= '0;
                        r_cw_valid     <= 1'b1;
                        r_state        <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem.mem_req  = w_fetching;
    assign mem.mem_addr = w_pc;

    assign command_word = r_command_word;
    assign cw_valid     = r_cw_valid;
    assign busy         = w_fetching;
    assign pc           = w_pc;
    assign dbg_state    = r_state;

endmodule : instr_fetch_unit
